// File: rtl/pipeline_sequencer.sv
// Parametrised multi-stage pipeline sequencer: steps one instruction through
// NUM_STATES states with per-state skip, wait-for-ready, global stall/flush
// and a retired-instruction counter.
module pipeline_sequencer #(
  parameter int unsigned           NUM_STATES = 7,
  parameter int unsigned           STATE_W    = 3,
  parameter logic [NUM_STATES-1:0] WAIT_MASK  = NUM_STATES'(7'b0000100),
  parameter int unsigned           COUNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  stageReady,
  input  logic [NUM_STATES-1:0] skipMask,
  output logic [NUM_STATES-1:0] stateOneHot,
  output logic [STATE_W-1:0]    stateIndex,
  output logic                  advance,
  output logic                  retire,
  output logic [COUNT_W-1:0]    retireCount
);

  // Wait mask widened to cover every encodable index so illegal indices read 0.
  localparam int unsigned            IDX_SPAN = 1 << STATE_W;
  localparam logic [IDX_SPAN-1:0]    WAIT_EXT = IDX_SPAN'(WAIT_MASK);

  logic [STATE_W-1:0] idx_q, idx_d;
  logic [STATE_W-1:0] idx_adv;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               idx_legal;
  logic               found;
  logic               wait_hold;

  assign idx_legal = (32'(idx_q) < NUM_STATES);
  assign wait_hold = WAIT_EXT[idx_q] && !stageReady;

  // Lowest non-skipped state above the current one; wraps to 0 if none.
  always_comb begin
    idx_adv = '0;
    found   = 1'b0;
    for (int unsigned j = 1; j < NUM_STATES; j++) begin
      if (!found && (j > 32'(idx_q)) && !skipMask[j]) begin
        idx_adv = STATE_W'(j);
        found   = 1'b1;
      end
    end
  end

  // Next-state and strobe decode: flush > stall > wait > advance.
  always_comb begin
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    advance = 1'b0;
    retire  = 1'b0;
    if (reset) begin
      if (flush || !idx_legal) begin
        idx_d = '0;
      end else if (!stall && !wait_hold) begin
        advance = 1'b1;
        idx_d   = idx_adv;
        retire  = (idx_adv == '0);
        if (retire) begin
          cnt_d = cnt_q + COUNT_W'(1);
        end
      end
    end
  end

  // State and retire counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end

  // Illegal indices decode to an all-zero one-hot vector.
  always_comb begin
    stateOneHot = '0;
    if (idx_legal) begin
      stateOneHot = NUM_STATES'(1) << idx_q;
    end
  end

  assign stateIndex  = idx_q;
  assign retireCount = cnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: a 7-state default instance and a
// 12-state / 4-bit-counter instance, exercised one after the other.
module tb_pipeline_sequencer;

  logic        clk = 1'b0;
  logic        rstA, rstB;
  logic        stall, flush, rdy;
  logic [6:0]  skipA;
  logic [11:0] skipB;

  logic [6:0]  ohA;
  logic [2:0]  idxA;
  logic        advA, retA;
  logic [31:0] cntA;

  logic [11:0] ohB;
  logic [3:0]  idxB;
  logic        advB, retB;
  logic [3:0]  cntB;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit     dut;
    int     idx;
    bit     adv;
    bit     ret;
    longint cnt;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pipeline_sequencer dutA (
    .clk(clk), .reset(rstA), .stall(stall), .flush(flush), .stageReady(rdy),
    .skipMask(skipA), .stateOneHot(ohA), .stateIndex(idxA), .advance(advA),
    .retire(retA), .retireCount(cntA)
  );

  pipeline_sequencer #(
    .NUM_STATES(12),
    .STATE_W(4),
    .COUNT_W(4)
  ) dutB (
    .clk(clk), .reset(rstB), .stall(stall), .flush(flush), .stageReady(rdy),
    .skipMask(skipB), .stateOneHot(ohB), .stateIndex(idxB), .advance(advB),
    .retire(retB), .retireCount(cntB)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus just after the edge and queue the outputs expected before the next edge.
  task automatic step(input bit dut, input bit rst, input bit st, input bit fl,
                      input bit rd, input logic [11:0] skip,
                      input int e_idx, input bit e_adv, input bit e_ret, input longint e_cnt);
    exp_t e;
    @(posedge clk);
    #1;
    stall = st;
    flush = fl;
    rdy   = rd;
    if (dut) begin
      rstB  = rst;
      skipB = skip;
    end else begin
      rstA  = rst;
      skipA = skip[6:0];
    end
    e.dut = dut; e.idx = e_idx; e.adv = e_adv; e.ret = e_ret; e.cnt = e_cnt;
    sb.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the oldest expectation mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.dut) begin
          chk("B.idx",    longint'(idxB), longint'(e.idx));
          chk("B.onehot", longint'(ohB),  longint'(1) << e.idx);
          chk("B.adv",    longint'(advB), longint'(e.adv));
          chk("B.ret",    longint'(retB), longint'(e.ret));
          chk("B.cnt",    longint'(cntB), e.cnt);
        end else begin
          chk("A.idx",    longint'(idxA), longint'(e.idx));
          chk("A.onehot", longint'(ohA),  longint'(1) << e.idx);
          chk("A.adv",    longint'(advA), longint'(e.adv));
          chk("A.ret",    longint'(retA), longint'(e.ret));
          chk("A.cnt",    longint'(cntA), e.cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int pos;
    rstA = 1'b0; rstB = 1'b0; stall = 1'b0; flush = 1'b0; rdy = 1'b0;
    skipA = '0; skipB = '0;

    // Reset state; strobes forced low even with stageReady high.
    step(0, 0, 0, 0, 1, 12'h000, 0, 0, 0, 0);

    // Free run: 0..6,0 with one retire per 7 cycles.
    for (int k = 0; k < 21; k++)
      step(0, 1, 0, 0, 1, 12'h000, k % 7, 1, (k % 7) == 6, k / 7);

    // memRead skip: loop 0..5.
    for (int k = 0; k < 12; k++)
      step(0, 1, 0, 0, 1, 12'h040, k % 6, 1, (k % 6) == 5, 3 + k / 6);

    // Wait state 2 holds until stageReady.
    step(0, 1, 0, 0, 0, 12'h000, 0, 1, 0, 5);
    step(0, 1, 0, 0, 0, 12'h000, 1, 1, 0, 5);
    repeat (3) step(0, 1, 0, 0, 0, 12'h000, 2, 0, 0, 5);
    step(0, 1, 0, 0, 1, 12'h000, 2, 1, 0, 5);
    step(0, 1, 0, 0, 0, 12'h000, 3, 1, 0, 5);

    // Stall at 4 for three cycles, then flush.
    repeat (3) step(0, 1, 1, 0, 1, 12'h000, 4, 0, 0, 5);
    step(0, 1, 0, 1, 1, 12'h000, 4, 0, 0, 5);

    // Flush on a would-be retire: no retire, no count.
    for (int k = 0; k < 6; k++)
      step(0, 1, 0, 0, 1, 12'h000, k, 1, 0, 5);
    step(0, 1, 0, 1, 1, 12'h000, 6, 0, 0, 5);

    // Flush and stall together: flush wins (back to 0).
    step(0, 1, 1, 1, 1, 12'h000, 0, 0, 0, 5);

    // skipMask ignored while stalled; sampled on the advance cycle.
    step(0, 1, 1, 0, 1, 12'h07E, 0, 0, 0, 5);
    step(0, 1, 0, 0, 1, 12'h000, 0, 1, 0, 5);
    step(0, 1, 0, 0, 1, 12'h07C, 1, 1, 1, 5);

    // Everything skipped from state 0: one-cycle loop, retire each cycle.
    for (int k = 0; k < 3; k++)
      step(0, 1, 0, 0, 1, 12'h07E, 0, 1, 1, 6 + k);

    // Reach idx 5 with count 9, then assert reset between edges.
    for (int k = 0; k < 5; k++)
      step(0, 1, 0, 0, 1, 12'h000, k, 1, 0, 9);
    step(0, 0, 0, 0, 1, 12'h000, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 12'h000, 0, 0, 0, 0);

    // 12-state instance: visits 0,1,3,5,7,9,11 and the 4-bit count wraps.
    step(1, 0, 0, 0, 1, 12'h554, 0, 0, 0, 0);
    for (int k = 0; k < 113; k++) begin
      pos = k % 7;
      step(1, 1, 0, 0, 1, 12'h554, (pos == 0) ? 0 : 2 * pos - 1, 1, pos == 6, (k / 7) % 16);
    end

    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
    chk("scoreboard.drain", longint'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
